id_pipe: RTL and testbench

ID_PIPE -- requirements
Module: id_pipe

---
 rtl/id_pipe_pkg.sv | 22 ++
 rtl/id_regfile.sv | 39 +++
 rtl/id_pipe.sv | 135 +++++++++++++
 tb/tb_id_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pipe_pkg.sv
// Shared decode definitions for id_pipe: destination-select encodings,
// MIPS instruction field positions and the link register index.
package id_pipe_pkg;

  typedef enum logic [1:0] {
    RD_SEL_RD   = 2'd0,
    RD_SEL_RT   = 2'd1,
    RD_SEL_LINK = 2'd2,
    RD_SEL_NONE = 2'd3
  } rd_sel_e;

  localparam int INSTR_W = 32;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;

  // Link destination is always the top register of the file.
  function automatic int link_index(input int reg_n);
    return reg_n - 1;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Two-read, one-write register file with write-through bypass on reads.
// Register 0 is hardwired to zero; asynchronous active-high reset clears all.
module id_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  localparam int AW    = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [REG_N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // A same-cycle write to the addressed register wins over the stored value.
  always_comb begin
    rdata1 = regs[raddr1];
    if (we && waddr == raddr1) rdata1 = wdata;
    if (raddr1 == '0) rdata1 = '0;
    rdata2 = regs[raddr2];
    if (we && waddr == raddr2) rdata2 = wdata;
    if (raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/id_pipe.sv
// Instruction-decode stage: register read, immediate extension, destination
// select, load-use stall and a valid/ready output register.
// Optional build macro ID_PIPE_FWD_EN adds MEM-stage forwarding on reads;
// without it, any pending EX/MEM write to a source register stalls instead.
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int IMM_W  = 16,
  localparam int AW    = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic [1:0]        ctl_rd_sel,
  input  logic              ctl_reg_wr,
  input  logic              ctl_is_load,
  input  logic              ctl_imm_sext,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mem_wr_en,
  input  logic [AW-1:0]     mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              ex_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_rdata1,
  output logic [DATA_W-1:0] out_rdata2,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc4,
  output logic [AW-1:0]     out_rs,
  output logic [AW-1:0]     out_rt,
  output logic [AW-1:0]     out_rd,
  output logic              out_reg_wr,
  output logic              out_is_load
);

  // Handshake: an instruction moves into the output register on a rising edge
  // where in_valid && in_ready; the output register is consumed on an edge
  // where out_valid && ex_ready. in_ready never depends on in_valid.

  logic [AW-1:0]     rs, rt, rd_field, dest;
  logic              dest_wr;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2, src1, src2, imm_ext;
  logic              out_hit, load_use, hazard, advance, accept;

  assign rs       = in_instr[RS_LSB +: AW];
  assign rt       = in_instr[RT_LSB +: AW];
  assign rd_field = in_instr[RD_LSB +: AW];

  id_regfile #(.DATA_W(DATA_W), .REG_N(REG_N)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  assign imm_ext = ctl_imm_sext ? DATA_W'($signed(in_instr[IMM_W-1:0]))
                                : DATA_W'(in_instr[IMM_W-1:0]);

  always_comb begin
    dest    = '0;
    dest_wr = 1'b0;
    unique case (rd_sel_e'(ctl_rd_sel))
      RD_SEL_RD:   begin dest = rd_field;                 dest_wr = ctl_reg_wr; end
      RD_SEL_RT:   begin dest = rt;                       dest_wr = ctl_reg_wr; end
      RD_SEL_LINK: begin dest = AW'(link_index(REG_N));   dest_wr = ctl_reg_wr; end
      default:     begin dest = '0;                       dest_wr = 1'b0;       end
    endcase
  end

  assign out_hit  = out_valid && out_reg_wr && out_rd != '0 &&
                    (out_rd == rs || out_rd == rt);
  assign load_use = out_hit && out_is_load;

`ifdef ID_PIPE_FWD_EN
  assign src1   = (mem_wr_en && mem_addr == rs && rs != '0) ? mem_data : rf_rdata1;
  assign src2   = (mem_wr_en && mem_addr == rt && rt != '0) ? mem_data : rf_rdata2;
  assign hazard = load_use;
`else
  logic mem_hit;
  logic unused_mem_data;
  assign mem_hit         = mem_wr_en && mem_addr != '0 &&
                           (mem_addr == rs || mem_addr == rt);
  assign src1            = rf_rdata1;
  assign src2            = rf_rdata2;
  assign hazard          = out_hit || mem_hit;
  assign unused_mem_data = ^mem_data;
`endif

  logic unused_instr;
  assign unused_instr = ^in_instr;

  assign advance  = !out_valid || ex_ready;
  assign in_ready = advance && !hazard;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_rdata1  <= '0;
      out_rdata2  <= '0;
      out_imm     <= '0;
      out_pc4     <= '0;
      out_rs      <= '0;
      out_rt      <= '0;
      out_rd      <= '0;
      out_reg_wr  <= 1'b0;
      out_is_load <= 1'b0;
    end else if (advance) begin
      out_valid <= accept;
      if (accept) begin
        out_rdata1  <= src1;
        out_rdata2  <= src2;
        out_imm     <= imm_ext;
        out_pc4     <= in_pc4;
        out_rs      <= rs;
        out_rt      <= rt;
        out_rd      <= dest;
        out_reg_wr  <= dest_wr;
        out_is_load <= ctl_is_load;
      end
    end
  end

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: a table of decode vectors plus hand-written
// stall, backpressure, forwarding and reset sequences.
module tb_id_pipe;

  localparam int DATA_W = 32;
  localparam int REG_N  = 32;
  localparam int IMM_W  = 16;
  localparam int AW     = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [31:0]       in_instr;
  logic [DATA_W-1:0] in_pc4;
  logic [1:0]        ctl_rd_sel;
  logic              ctl_reg_wr, ctl_is_load, ctl_imm_sext;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              mem_wr_en;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              ex_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_rdata1, out_rdata2, out_imm, out_pc4;
  logic [AW-1:0]     out_rs, out_rt, out_rd;
  logic              out_reg_wr, out_is_load;

  int n_pass  = 0;
  int n_total = 0;
  logic [DATA_W-1:0] exp_q[$];

  id_pipe #(.DATA_W(DATA_W), .REG_N(REG_N), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc4(in_pc4), .ctl_rd_sel(ctl_rd_sel),
    .ctl_reg_wr(ctl_reg_wr), .ctl_is_load(ctl_is_load), .ctl_imm_sext(ctl_imm_sext),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .ex_ready(ex_ready), .out_valid(out_valid), .out_rdata1(out_rdata1),
    .out_rdata2(out_rdata2), .out_imm(out_imm), .out_pc4(out_pc4),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_reg_wr(out_reg_wr), .out_is_load(out_is_load)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [1:0]  rd_sel;
    logic        reg_wr;
    logic        sext;
    logic [31:0] e_r1;
    logic [31:0] e_r2;
    logic [31:0] e_imm;
    logic [4:0]  e_rd;
    logic        e_wr;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [31:0] mk(input logic [4:0] s, input logic [4:0] t,
                                     input logic [15:0] imm);
    return {6'd0, s, t, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic set_instr(input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm,
                           input logic [1:0] sel, input logic wr, input logic ld,
                           input logic sx, input logic [31:0] pc4);
    in_valid     = 1'b1;
    in_instr     = mk(s, t, imm);
    ctl_rd_sel   = sel;
    ctl_reg_wr   = wr;
    ctl_is_load  = ld;
    ctl_imm_sext = sx;
    in_pc4       = pc4;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b0;
    wb_en    = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    tick();
    wb_en    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc4 = '0; ctl_rd_sel = 2'd3;
    ctl_reg_wr = 1'b0; ctl_is_load = 1'b0; ctl_imm_sext = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    mem_wr_en = 1'b0; mem_addr = '0; mem_data = '0; ex_ready = 1'b1;

    vecs[0] = '{mk(5'd1, 5'd2, 16'h1800),  32'h104, 2'd0, 1'b1, 1'b1,
                32'h11111111, 32'h22222222, 32'h00001800, 5'd3,  1'b1};
    vecs[1] = '{mk(5'd2, 5'd0, 16'h8000),  32'h108, 2'd1, 1'b1, 1'b1,
                32'h22222222, 32'h00000000, 32'hFFFF8000, 5'd0,  1'b1};
    vecs[2] = '{mk(5'd0, 5'd1, 16'h8000),  32'h10C, 2'd2, 1'b1, 1'b0,
                32'h00000000, 32'h11111111, 32'h00008000, 5'd31, 1'b1};
    vecs[3] = '{mk(5'd7, 5'd2, 16'hFFFF),  32'h110, 2'd3, 1'b1, 1'b1,
                32'h00000077, 32'h22222222, 32'hFFFFFFFF, 5'd0,  1'b0};
    vecs[4] = '{mk(5'd31, 5'd1, 16'h5A5A), 32'h114, 2'd0, 1'b0, 1'b1,
                32'h00000000, 32'h11111111, 32'h00005A5A, 5'd11, 1'b0};

    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_rdata1", out_rdata1, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    wb_write(5'd1, 32'h11111111);
    wb_write(5'd2, 32'h22222222);
    wb_write(5'd7, 32'h00000077);

    // Table of decode vectors, back to back with ex_ready=1
    for (int i = 0; i < 5; i++) begin
      set_instr(vecs[i].instr[25:21], vecs[i].instr[20:16], vecs[i].instr[15:0],
                vecs[i].rd_sel, vecs[i].reg_wr, 1'b0, vecs[i].sext, vecs[i].pc4);
      #1;
      check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      exp_q.push_back(vecs[i].e_r1);
      tick();
      check($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("v%0d_rdata1", i), out_rdata1, exp_q.pop_front());
      check($sformatf("v%0d_rdata2", i), out_rdata2, vecs[i].e_r2);
      check($sformatf("v%0d_imm", i), out_imm, vecs[i].e_imm);
      check($sformatf("v%0d_pc4", i), out_pc4, vecs[i].pc4);
      check($sformatf("v%0d_rd", i), {27'd0, out_rd}, {27'd0, vecs[i].e_rd});
      check($sformatf("v%0d_reg_wr", i), {31'd0, out_reg_wr}, {31'd0, vecs[i].e_wr});
      check($sformatf("v%0d_is_load", i), {31'd0, out_is_load}, 32'd0);
    end

    // Writeback bypass into the same-cycle read; write to r0 discarded
    in_valid = 1'b0;
    tick();
    set_instr(5'd5, 5'd0, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b0, 32'h200);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    tick();
    check("bypass_rdata1", out_rdata1, 32'h1234);
    set_instr(5'd5, 5'd0, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b0, 32'h204);
    wb_addr = 5'd0; wb_data = 32'hDEAD;
    tick();
    wb_en = 1'b0;
    check("r5_stored", out_rdata1, 32'h1234);
    check("r0_zero", out_rdata2, 32'h0);

    // Load-use: one bubble, and a writeback during the stall is reread
    set_instr(5'd0, 5'd3, 16'h0000, 2'd1, 1'b1, 1'b1, 1'b0, 32'h300);
    tick();
    check("load_is_load", {31'd0, out_is_load}, 32'd1);
    set_instr(5'd3, 5'd0, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b0, 32'h304);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h333;
    #1;
    check("lu_in_ready_stall", {31'd0, in_ready}, 32'd0);
    tick();
    wb_en = 1'b0;
    check("lu_bubble", {31'd0, out_valid}, 32'd0);
    check("lu_in_ready_retry", {31'd0, in_ready}, 32'd1);
    tick();
    check("lu_accept_valid", {31'd0, out_valid}, 32'd1);
    check("lu_accept_rs", {27'd0, out_rs}, 32'd3);
    check("lu_reread_wb", out_rdata1, 32'h333);

    // Backpressure: output register holds for three cycles
    set_instr(5'd1, 5'd2, 16'h0042, 2'd3, 1'b0, 1'b0, 1'b0, 32'h400);
    ex_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      tick();
      check($sformatf("bp%0d_rs", c), {27'd0, out_rs}, 32'd3);
      check($sformatf("bp%0d_pc4", c), out_pc4, 32'h304);
      check($sformatf("bp%0d_rdata1", c), out_rdata1, 32'h333);
      check($sformatf("bp%0d_valid", c), {31'd0, out_valid}, 32'd1);
    end
    ex_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_next_rs", {27'd0, out_rs}, 32'd1);
    check("bp_next_rdata1", out_rdata1, 32'h11111111);
    check("bp_next_imm", out_imm, 32'h42);

    // Pending MEM write vs writeback on rt=7
    set_instr(5'd0, 5'd7, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b0, 32'h500);
    mem_wr_en = 1'b1; mem_addr = 5'd7; mem_data = 32'hAA;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hBB;
`ifdef ID_PIPE_FWD_EN
    #1;
    check("fwd_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    mem_wr_en = 1'b0; wb_en = 1'b0;
    check("fwd_rdata2", out_rdata2, 32'hAA);
`else
    #1;
    check("nofwd_stall", {31'd0, in_ready}, 32'd0);
    tick();
    check("nofwd_bubble", {31'd0, out_valid}, 32'd0);
    check("nofwd_still_stalled", {31'd0, in_ready}, 32'd0);
    tick();
    mem_wr_en = 1'b0; wb_en = 1'b0;
    #1;
    check("nofwd_release", {31'd0, in_ready}, 32'd1);
    tick();
    check("nofwd_rdata2", out_rdata2, 32'hBB);
`endif

    // Reset in the middle of a load-use stall
    set_instr(5'd0, 5'd4, 16'h0000, 2'd1, 1'b1, 1'b1, 1'b0, 32'h600);
    tick();
    set_instr(5'd4, 5'd0, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b0, 32'h604);
    #1;
    check("rst_stall_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    #1;
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_rd", {27'd0, out_rd}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst = 1'b0; wb_en = 1'b0;
    set_instr(5'd1, 5'd2, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b0, 32'h700);
    tick();
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_r1", out_rdata1, 32'h0);
    check("post_rst_r2", out_rdata2, 32'h0);
    set_instr(5'd9, 5'd5, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b0, 32'h704);
    tick();
    check("post_rst_r9", out_rdata1, 32'h0);
    check("post_rst_r5", out_rdata2, 32'h0);
    in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
